// File: rtl/capture_session_ctrl_if.sv
// capture_session_ctrl_if: source handshake and capture FIFO write/flag signals
// for one capture session controller. The master modport is the controller side.
interface capture_session_ctrl_if;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_rden;
   logic        fifo_rst;
   logic        fifo_wr_en;
   logic [31:0] fifo_din;
   logic        eof;

   modport master (
      input  src_valid, src_data, fifo_full, fifo_empty, fifo_rden,
      output src_ready, fifo_rst, fifo_wr_en, fifo_din, eof
   );

   modport slave (
      output src_valid, src_data, fifo_full, fifo_empty, fifo_rden,
      input  src_ready, fifo_rst, fifo_wr_en, fifo_din, eof
   );
endinterface

// File: rtl/capture_session_ctrl.sv
// capture_session_ctrl: sequences one host capture session on the 32-bit capture
// FIFO path (IDLE -> FLUSH -> RUN -> LAST -> STOP). Holds the FIFO in reset while
// the stream is closed, gates paced source words into the FIFO, stops on overflow
// or word limit and raises eof once the FIFO drains.
// Optional build macro: CAPTURE_HEADER_EN -- when defined, the first write of each
// session is the header word {16'hCA5E, session_id[15:0]}.
module capture_session_ctrl #(
   parameter int unsigned MAX_WORDS = 0,
   parameter int unsigned PACE_LOG2 = 0,
   parameter int unsigned FLUSH_CYC = 8,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                   bus_clk,
   input  logic                   rst_n,
   input  logic                   stream_open,
   capture_session_ctrl_if.master bus,
   output logic                   overflow,
   output logic [CNT_W-1:0]       words_captured
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FLUSH = 3'd1,
      S_RUN   = 3'd2,
      S_LAST  = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   localparam int unsigned      FLUSH_W    = $clog2(FLUSH_CYC);
   localparam int unsigned      PACE_W     = (PACE_LOG2 > 0) ? PACE_LOG2 : 1;
   localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;
   localparam logic [CNT_W-1:0] LIMIT_PREV = CNT_W'(MAX_WORDS - 1);

   state_t             state_reg;
   state_t             state_next;
   logic [FLUSH_W-1:0] flush_cnt_reg;
   logic [PACE_W-1:0]  pace_cnt_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               overflow_reg;

   logic               pace_tick;
   logic               at_limit;
   logic               rst_cmd;
   logic               wr_cmd;
   logic [31:0]        wr_data;
   logic               accept;
   logic               eof_flag;
   logic               ovf_set;

`ifdef CAPTURE_HEADER_EN
   logic [15:0]        session_id_reg;
   logic [15:0]        hdr_id_reg;
   logic               hdr_done_reg;
   logic               hdr_wr;
`endif

   // With no pacing every RUN cycle is a write slot.
   assign pace_tick = (PACE_LOG2 == 0) || (pace_cnt_reg == '0);
   // A write in this cycle would bring the session count up to the word limit.
   assign at_limit  = (MAX_WORDS != 0) && (count_reg == LIMIT_PREV);

   // Next-state and FIFO-side outputs; closing the stream overrides every state.
   always_comb begin
      state_next = state_reg;
      rst_cmd    = 1'b0;
      wr_cmd     = 1'b0;
      wr_data    = '0;
      accept     = 1'b0;
      eof_flag   = 1'b0;
      ovf_set    = 1'b0;
`ifdef CAPTURE_HEADER_EN
      hdr_wr     = 1'b0;
`endif
      case (state_reg)
         S_IDLE: begin
            rst_cmd = 1'b1;
            if (stream_open) state_next = S_FLUSH;
         end
         S_FLUSH: begin
            rst_cmd = 1'b1;
            if (flush_cnt_reg == FLUSH_END) state_next = S_RUN;
         end
         S_RUN: begin
`ifdef CAPTURE_HEADER_EN
            if (!hdr_done_reg) begin
               if (pace_tick) begin
                  if (bus.fifo_full) begin
                     ovf_set    = 1'b1;
                     state_next = S_STOP;
                  end else begin
                     wr_cmd  = 1'b1;
                     hdr_wr  = 1'b1;
                     wr_data = {16'hCA5E, hdr_id_reg};
                     if (at_limit) state_next = S_LAST;
                  end
               end
            end else
`endif
            begin
               if (bus.src_valid && pace_tick) begin
                  if (bus.fifo_full) begin
                     // Word is dropped; the session ends as an overflow.
                     ovf_set    = 1'b1;
                     state_next = S_STOP;
                  end else begin
                     wr_cmd  = 1'b1;
                     accept  = 1'b1;
                     wr_data = bus.src_data;
                     if (at_limit) state_next = S_LAST;
                  end
               end
            end
         end
         S_LAST: begin
            // Wait until the host side sees data so eof follows at least one read.
            if (!bus.fifo_empty) state_next = S_STOP;
         end
         S_STOP: begin
            eof_flag = bus.fifo_empty;
         end
         default: state_next = S_IDLE;
      endcase
      if (!stream_open) state_next = S_IDLE;
   end

   // State register plus flush timer, pace counter, word count and overflow flag.
   always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         flush_cnt_reg <= '0;
         pace_cnt_reg  <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_FLUSH) flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
         else                      flush_cnt_reg <= '0;
         if (state_reg == S_RUN)   pace_cnt_reg  <= pace_cnt_reg + PACE_W'(1);
         else                      pace_cnt_reg  <= '0;
         if (state_next == S_IDLE) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
         end else begin
            if (wr_cmd && (count_reg != CNT_SAT)) count_reg <= count_reg + CNT_W'(1);
            if (ovf_set) overflow_reg <= 1'b1;
         end
      end
   end

`ifdef CAPTURE_HEADER_EN
   // Session numbering: the id is latched at open and the running id advances.
   always_ff @(posedge bus_clk or negedge rst_n) begin
      if (!rst_n) begin
         session_id_reg <= '0;
         hdr_id_reg     <= '0;
         hdr_done_reg   <= 1'b0;
      end else begin
         if ((state_reg == S_IDLE) && (state_next == S_FLUSH)) begin
            hdr_id_reg     <= session_id_reg;
            session_id_reg <= session_id_reg + 16'd1;
         end
         if (state_reg != S_RUN) hdr_done_reg <= 1'b0;
         else if (hdr_wr)        hdr_done_reg <= 1'b1;
      end
   end
`endif

   // A host read of an empty FIFO indicates a broken read side.
   rden_not_empty: assert property (@(posedge bus_clk) disable iff (!rst_n)
      !(bus.fifo_rden && bus.fifo_empty));

   assign bus.fifo_rst    = rst_cmd;
   assign bus.fifo_wr_en  = wr_cmd;
   assign bus.fifo_din    = wr_data;
   assign bus.src_ready   = accept;
   assign bus.eof         = eof_flag;
   assign overflow        = overflow_reg;
   assign words_captured  = count_reg;

endmodule

// File: tb/tb_capture_session_ctrl.sv
// tb_capture_session_ctrl: directed bench for capture_session_ctrl with a scoreboard
// of expected FIFO write words. Instance A is unlimited/unpaced, instance B has a
// four-word limit and one write slot per four cycles. Build macro CAPTURE_HEADER_EN
// switches the expectations to header-first sessions.
`timescale 1ns/1ps
module tb_capture_session_ctrl;

   logic        bus_clk = 1'b0;
   logic        rst_n;
   logic        open_a, open_b;
   logic        src_valid, fifo_full, fifo_empty, fifo_rden;
   logic [31:0] src_data;
   logic        ovf_a, ovf_b;
   logic [31:0] cnt_a, cnt_b;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] exp_cnt;
   logic [15:0] sess_a, sess_b;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   always #5 bus_clk = ~bus_clk;

   capture_session_ctrl_if ifa ();
   capture_session_ctrl_if ifb ();

   assign ifa.src_valid  = src_valid;
   assign ifa.src_data   = src_data;
   assign ifa.fifo_full  = fifo_full;
   assign ifa.fifo_empty = fifo_empty;
   assign ifa.fifo_rden  = fifo_rden;
   assign ifb.src_valid  = src_valid;
   assign ifb.src_data   = src_data;
   assign ifb.fifo_full  = fifo_full;
   assign ifb.fifo_empty = fifo_empty;
   assign ifb.fifo_rden  = fifo_rden;

   capture_session_ctrl #(.MAX_WORDS(0), .PACE_LOG2(0), .FLUSH_CYC(8), .CNT_W(32)) u_dut_a (
      .bus_clk(bus_clk), .rst_n(rst_n), .stream_open(open_a), .bus(ifa),
      .overflow(ovf_a), .words_captured(cnt_a)
   );

   capture_session_ctrl #(.MAX_WORDS(4), .PACE_LOG2(2), .FLUSH_CYC(8), .CNT_W(32)) u_dut_b (
      .bus_clk(bus_clk), .rst_n(rst_n), .stream_open(open_b), .bus(ifb),
      .overflow(ovf_b), .words_captured(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Scoreboard side: every FIFO write must match the oldest expected word.
   always @(negedge bus_clk) begin
      #2;
      if (ifa.fifo_wr_en === 1'b1) begin
         if (qa.size() == 0) check("a_unexpected_wr", {31'd0, ifa.fifo_wr_en}, 32'd0);
         else                check("a_din", ifa.fifo_din, qa.pop_front());
      end
      if (ifb.fifo_wr_en === 1'b1) begin
         if (qb.size() == 0) check("b_unexpected_wr", {31'd0, ifb.fifo_wr_en}, 32'd0);
         else                check("b_din", ifb.fifo_din, qb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic open_flush_a();
      @(negedge bus_clk);
      open_a    = 1'b1;
      src_valid = 1'b1;
      sess_a    = sess_a + 16'd1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge bus_clk);
         #1;
         check("a_flush_rst", ifa.fifo_rst, 1);
         check("a_flush_wr", ifa.fifo_wr_en, 0);
      end
      exp_cnt = 0;
   endtask

   task automatic run_entry_a();
`ifdef CAPTURE_HEADER_EN
      @(negedge bus_clk);
      qa.push_back({16'hCA5E, sess_a - 16'd1});
      #1;
      check("a_hdr_wr", ifa.fifo_wr_en, 1);
      check("a_hdr_ready", ifa.src_ready, 0);
      exp_cnt = 1;
`endif
   endtask

   task automatic write_words_a(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge bus_clk);
         src_data = $urandom;
         qa.push_back(src_data);
         #1;
         check("a_run_rst", ifa.fifo_rst, 0);
         check("a_run_wr", ifa.fifo_wr_en, 1);
         check("a_run_ready", ifa.src_ready, 1);
         check("a_run_cnt", cnt_a, exp_cnt);
         exp_cnt = exp_cnt + 1;
      end
   endtask

   task automatic close_a();
      @(negedge bus_clk);
      open_a    = 1'b0;
      src_valid = 1'b0;
      @(negedge bus_clk);
      #1;
      check("a_closed_rst", ifa.fifo_rst, 1);
      check("a_closed_cnt", cnt_a, 0);
      check("a_closed_ovf", ovf_a, 0);
      check("a_closed_eof", ifa.eof, 0);
   endtask

   initial begin
      rst_n = 1'b0; open_a = 1'b0; open_b = 1'b0;
      src_valid = 1'b0; src_data = '0; fifo_full = 1'b0; fifo_empty = 1'b1; fifo_rden = 1'b0;
      exp_cnt = 0; sess_a = 0; sess_b = 0;
      repeat (2) @(negedge bus_clk);
      #1;
      check("rst_fifo_rst", ifa.fifo_rst, 1);
      check("rst_wr_en", ifa.fifo_wr_en, 0);
      check("rst_din", ifa.fifo_din, 0);
      check("rst_src_ready", ifa.src_ready, 0);
      check("rst_eof", ifa.eof, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_cnt", cnt_a, 0);
      rst_n = 1'b1;

      // Continuous capture, then a reopen that must run the full flush again.
      open_flush_a(); run_entry_a(); write_words_a(6); close_a();
      open_flush_a(); run_entry_a(); write_words_a(2); close_a();

      // Overflow: full FIFO with a pending word ends the session.
      open_flush_a(); run_entry_a(); write_words_a(2);
      @(negedge bus_clk);
      fifo_full = 1'b1; fifo_empty = 1'b0; src_data = $urandom;
      #1;
      check("ovf_wr", ifa.fifo_wr_en, 0);
      check("ovf_ready", ifa.src_ready, 0);
      @(negedge bus_clk);
      #1;
      check("ovf_flag", ovf_a, 1);
      check("ovf_eof_nonempty", ifa.eof, 0);
      check("ovf_cnt", cnt_a, exp_cnt);
      @(negedge bus_clk);
      fifo_full = 1'b0;
      #1;
      check("stop_wr", ifa.fifo_wr_en, 0);
      @(negedge bus_clk);
      fifo_empty = 1'b1;
      #1;
      check("ovf_eof_empty", ifa.eof, 1);
      close_a();

      // Asynchronous reset in the middle of RUN.
      open_flush_a(); run_entry_a(); write_words_a(2);
      @(negedge bus_clk);
      src_data = $urandom;
      qa.push_back(src_data);
      #3;
      rst_n = 1'b0; open_a = 1'b0; src_valid = 1'b0;
      #1;
      check("arst_fifo_rst", ifa.fifo_rst, 1);
      check("arst_wr_en", ifa.fifo_wr_en, 0);
      check("arst_din", ifa.fifo_din, 0);
      check("arst_cnt", cnt_a, 0);
      check("arst_ovf", ovf_a, 0);
      @(negedge bus_clk);
      #1;
      rst_n = 1'b1;
      sess_a = 0;

      // Instance B: paced writes, word limit, LAST wait and eof after the drain.
      @(negedge bus_clk);
      open_b = 1'b1; src_valid = 1'b1; fifo_empty = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge bus_clk);
         #1;
         check("b_flush_rst", ifb.fifo_rst, 1);
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge bus_clk);
         src_data = $urandom;
         if ((k % 4) == 0 && k < 13) begin
`ifdef CAPTURE_HEADER_EN
            if (k == 0) qb.push_back({16'hCA5E, sess_b});
            else        qb.push_back(src_data);
`else
            qb.push_back(src_data);
`endif
            #1;
            check("b_pace_wr", ifb.fifo_wr_en, 1);
         end else begin
            #1;
            check("b_pace_idle", ifb.fifo_wr_en, 0);
            check("b_pace_ready", ifb.src_ready, 0);
         end
      end
      @(negedge bus_clk);
      #1;
      check("b_limit_cnt", cnt_b, 4);
      check("b_last_eof", ifb.eof, 0);
      @(negedge bus_clk);
      fifo_empty = 1'b0;
      #1;
      check("b_last_nonempty_eof", ifb.eof, 0);
      for (int r = 0; r < 4; r++) begin
         @(negedge bus_clk);
         fifo_rden = 1'b1;
         #1;
         check("b_read_eof", ifb.eof, 0);
         check("b_stop_wr", ifb.fifo_wr_en, 0);
      end
      @(negedge bus_clk);
      fifo_rden = 1'b0; fifo_empty = 1'b1;
      #1;
      check("b_drained_eof", ifb.eof, 1);
      @(negedge bus_clk);
      open_b = 1'b0;
      #1;
      check("b_close_same_cycle_eof", ifb.eof, 1);
      @(negedge bus_clk);
      #1;
      check("b_close_next_eof", ifb.eof, 0);
      check("b_close_cnt", cnt_b, 0);

      repeat (2) @(negedge bus_clk);
      check("a_queue_left", qa.size(), 0);
      check("b_queue_left", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
